uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single transmitter of one `Uart8` instance among `NUM_REQ` byte producers. It applies round-robin arbitration with per-frame locking and sequences the transmitter's start/busy/done handshake. A watchdog recovers from a transmitter that never reports completion. It sits between requester logic and the `Uart8` tx interface.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `DONE_TIMEOUT`, default 20000: cycles allowed in WAIT_DONE before abort (covers 10 bits at 9600 baud from 12 MHz plus margin).
- `LOCK_IDLE`, default 2048: cycles a locked owner may keep `req` low before the lock is dropped.
- `clk`, input, 1: clock, rising edge.
- `rstN`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: allows new grants.
- `req`, input, NUM_REQ: requester i has a byte pending.
- `reqData`, input, NUM_REQ*8: byte of requester i in bits [8i+7:8i].
- `reqLast`, input, NUM_REQ: the pending byte is the last byte of its frame.
- `ack`, output, NUM_REQ: one-cycle pulse; requester's byte has been captured.
- `owner`, output, max(1,$clog2(NUM_REQ)): index of the current or last grantee.
- `ownerValid`, output, 1: a transfer is in progress or a lock is held.
- `timeoutErr`, output, 1: one-cycle pulse on watchdog abort.
- `txEn`, output, 1: drives the transmitter enable.
- `txStart`, output, 1: one-cycle start strobe.
- `txData`, output, 8: byte to the transmitter.
- `txBusy`, input, 1: transmitter busy.
- `txDone`, input, 1: transmitter completion pulse.

## Operation
- States: IDLE, START, WAIT_DONE.
- IDLE:
  - A grant occurs when `enable`=1, `txBusy`=0 and the candidate set is non-empty.
  - Candidate set: only `owner` if locked, else all asserted `req`.
  - Pick: first asserted candidate searching from `ptr`, wrapping modulo NUM_REQ.
  - On grant: capture `txData`<=reqData[g] and `owner`<=g, latch reqLast[g] into `lastFlag`, go to START.
- START: `txStart`=1 and `ack[owner]`=1 for exactly this cycle, then go to WAIT_DONE. Watchdog is cleared.
- WAIT_DONE:
  - On `txDone`=1: go to IDLE and set `ptr`<=owner+1 (wrapping).
    - If `lastFlag`, clear the lock; otherwise set the lock.
  - If the watchdog reaches DONE_TIMEOUT first: pulse `timeoutErr`, clear the lock, set `ptr`<=owner+1, go to IDLE.
- Lock idle counter:
  - Runs only in IDLE while locked and req[owner]=0. Reset when req[owner]=1.
  - At LOCK_IDLE it clears the lock.
- `enable`=0:
  - No new grants.
  - An in-flight transfer completes normally.
  - In IDLE, the lock is cleared.
- `txEn` = `enable` OR (state != IDLE).
- `ownerValid` = (state != IDLE) OR locked.
- `txData` holds its value from capture until the next grant.
- Simultaneous events:
  - `txDone` and watchdog expiry in the same cycle: `txDone` wins, no error.
  - `req` dropping in the START cycle does not cancel the transfer.
- Requesters must hold `reqData`/`reqLast` stable while `req`=1 until they see `ack`. They may change them at the following edge.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, lock clear, counters 0.
  - `ack`, `txStart`, `timeoutErr`, `ownerValid` all 0.
  - `owner`=0, `txData`=0x00, `txEn`=0 until `enable`.
- Grant decided in cycle N (IDLE) → `txStart` and `ack` in cycle N+1 → WAIT_DONE from N+2.
- `txDone` in cycle M → IDLE in M+1 → earliest next `txStart` in M+2.
- Watchdog counts cycles from N+2. Abort occurs in the cycle the count equals DONE_TIMEOUT, with `timeoutErr` asserted that cycle and IDLE the next.
- Reset mid-operation: immediate return to reset values. No `ack` is issued for a byte captured but not started.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum (IDLE/START/WAIT_DONE);
  - a function computing the `owner` width;
  - the default timeout constants.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, start pointer.
  - Outputs: grant index and a valid flag.
  - Reusable by a future rx dispatcher.
- Counters are sized $clog2(DONE_TIMEOUT+1) and $clog2(LOCK_IDLE+1).

## Test plan
- Single requester: req[2]=1, data 0x35, last=1, txDone 10 cycles after start → `txStart` and ack[2] in the same cycle, `txData`=0x35, lock clear afterwards.
- Fairness: all 4 req held with last=1 and `ptr`=0 → grant order 0,1,2,3,0, one `txStart` per `txDone`.
- Frame lock: req0 sends 3 bytes (last on the 3rd) while req1 is asserted throughout → grants 0,0,0 then 1.
- Lock idle: req0 sends one non-last byte, then drops req for LOCK_IDLE cycles while req3=1 → lock drops and req3 is granted.
- Watchdog: grant, then no `txDone` → `timeoutErr` pulse exactly DONE_TIMEOUT cycles after WAIT_DONE entry, return to IDLE, next requester granted.
- Reset mid-WAIT_DONE with `enable` toggled low → all outputs return to reset values. With `enable`=0, no grant occurs despite pending requests.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side controllers.
package uart_ctrl_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } txState_t;

  // Default watchdog: 10 bits at 9600 baud from 12 MHz is 12500 cycles, plus margin
  localparam int DEF_DONE_TIMEOUT = 20000;
  // Default number of cycles a locked owner may stay silent before losing the lock
  localparam int DEF_LOCK_IDLE    = 2048;

  // Width of a requester index; never narrower than one bit
  function automatic int ownerWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after startPtr,
// wrapping modulo N. Kept generic so an rx dispatcher can reuse it.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  reqVec,
  input  logic [IW-1:0] startPtr,
  output logic [IW-1:0] grantIdx,
  output logic          grantValid
);

  logic [IW-1:0] idx;
  logic          hit;

  // Scan from the farthest offset down so the nearest asserted request wins last
  always_comb begin
    grantIdx   = '0;
    grantValid = 1'b0;
    idx        = '0;
    hit        = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx        = IW'((int'(startPtr) + k) % N);
      hit        = reqVec[idx];
      grantIdx   = hit ? idx : grantIdx;
      grantValid = grantValid | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter among NUM_REQ byte producers with round-robin
// arbitration, per-frame locking, start/done sequencing and a completion watchdog.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter int LOCK_IDLE    = DEF_LOCK_IDLE
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*8-1:0]           reqData,
  input  logic [NUM_REQ-1:0]             reqLast,
  output logic [NUM_REQ-1:0]             ack,
  output logic [ownerWidth(NUM_REQ)-1:0] owner,
  output logic                           ownerValid,
  output logic                           timeoutErr,
  output logic                           txEn,
  output logic                           txStart,
  output logic [7:0]                     txData,
  input  logic                           txBusy,
  input  logic                           txDone
);

  localparam int OW = ownerWidth(NUM_REQ);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_IDLE + 1);

  txState_t           state;
  logic [OW-1:0]      ptr;
  logic               locked;
  logic               lastFlag;
  logic [TW-1:0]      wdCnt;
  logic [LW-1:0]      idleCnt;

  logic [NUM_REQ-1:0] candVec;
  logic [OW-1:0]      pickIdx;
  logic               pickValid;
  logic [OW-1:0]      ptrAfter;
  logic               ownerReq;

  assign ownerReq   = req[owner];
  assign ptrAfter   = (int'(owner) == NUM_REQ - 1) ? '0 : owner + OW'(1);
  assign txEn       = enable | (state != ST_IDLE);
  assign ownerValid = (state != ST_IDLE) | locked;

  // While a frame lock is held only the owner may be granted
  always_comb begin
    candVec = req;
    if (locked) begin
      candVec = req & (NUM_REQ'(1) << owner);
    end else begin
      candVec = req;
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) uPick (
    .reqVec     (candVec),
    .startPtr   (ptr),
    .grantIdx   (pickIdx),
    .grantValid (pickValid)
  );

  // Arbitration FSM with lock/watchdog counters and registered transmitter strobes
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      locked     <= 1'b0;
      lastFlag   <= 1'b0;
      wdCnt      <= '0;
      idleCnt    <= '0;
      ack        <= '0;
      owner      <= '0;
      txStart    <= 1'b0;
      txData     <= 8'h00;
      timeoutErr <= 1'b0;
    end else begin
      ack        <= '0;
      txStart    <= 1'b0;
      timeoutErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!enable) begin
            locked  <= 1'b0;
            idleCnt <= '0;
          end else if (!txBusy && pickValid) begin
            txData   <= reqData[int'(pickIdx)*8 +: 8];
            owner    <= pickIdx;
            lastFlag <= reqLast[pickIdx];
            ack      <= NUM_REQ'(1) << pickIdx;
            txStart  <= 1'b1;
            idleCnt  <= '0;
            state    <= ST_START;
          end else if (locked && !ownerReq) begin
            // Owner went quiet mid-frame: release after LOCK_IDLE silent cycles
            if (idleCnt == LW'(LOCK_IDLE - 1)) begin
              locked  <= 1'b0;
              idleCnt <= '0;
            end else begin
              idleCnt <= idleCnt + LW'(1);
            end
          end else begin
            idleCnt <= '0;
          end
        end
        ST_START: begin
          wdCnt <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // txDone takes priority over a watchdog expiry in the same cycle
          if (txDone) begin
            locked  <= ~lastFlag;
            ptr     <= ptrAfter;
            idleCnt <= '0;
            state   <= ST_IDLE;
          end else if (wdCnt == TW'(DONE_TIMEOUT - 1)) begin
            timeoutErr <= 1'b1;
            locked     <= 1'b0;
            ptr        <= ptrAfter;
            idleCnt    <= '0;
            state      <= ST_IDLE;
          end else begin
            wdCnt <= wdCnt + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
